uart_tx_scheduler: RTL and testbench



---
 rtl/uart_tx_scheduler_pkg.sv | 25 ++
 rtl/uart_tx_scheduler_rr_arbiter.sv | 27 ++
 rtl/uart_tx_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 494 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and helpers for the UART transmit scheduler.
//   tx_sched_state_e : scheduler FSM states
//   NUM_TX_REQ       : default number of byte-stream requesters
//   onehot_to_idx    : encodes a one-hot vector (up to 8 bits) to its index
package uart_tx_scheduler_pkg;

  localparam int unsigned NUM_TX_REQ = 4;

  typedef enum logic [1:0] {
    StIdle,
    StXfer,
    StDrain,
    StCfg
  } tx_sched_state_e;

  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at or
// after ptr, wrapping cyclically.
//   req : request vector
//   ptr : index with highest priority this round
//   gnt : one-hot grant (all zero when no request)
module uart_tx_scheduler_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt
);

  logic [NUM_REQ-1:0] mask;
  logic [NUM_REQ-1:0] hi;
  logic [NUM_REQ-1:0] sel;

  always_comb begin
    // Bits at or above ptr; if none of those request, wrap to the lowest requester.
    mask = ~((NUM_REQ'(1) << ptr) - NUM_REQ'(1));
    hi   = req & mask;
    sel  = (|hi) ? hi : req;
    // Isolate the lowest set bit.
    gnt  = sel & (~sel + NUM_REQ'(1));
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares the UART TX FIFO between NUM_REQ byte-stream requesters and a
// configuration source. Requesters are granted round-robin per packet, with
// a burst cap forcing re-arbitration. A configuration request waits for the
// current packet, drains the FIFO and in-flight frames, then holds
// config_req_mst_o until the transmitter reports req_done_i.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   req_valid/data/last_i   : per-requester byte stream
//   req_ready_o, grant_o    : per-requester accept, one-hot grant
//   cfg_req_i               : configuration request pulse
//   cfg_busy_o, cfg_ack_o   : config pending/active, completion pulse
//   tx_data_o, tx_fifo_*    : TX FIFO write side and status
//   tx_done_i               : one pulse per transmitted frame
//   req_done_i              : transmitter finished configuration
//   config_req_mst_o        : level configuration request to transmitter
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ     = NUM_TX_REQ,
  parameter int unsigned MAX_BURST   = 16,
  parameter int unsigned OUTST_DEPTH = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [NUM_REQ*8-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [NUM_REQ-1:0]   grant_o,
  input  logic                 cfg_req_i,
  output logic                 cfg_busy_o,
  output logic                 cfg_ack_o,
  output logic [7:0]           tx_data_o,
  output logic                 tx_fifo_write_o,
  input  logic                 tx_fifo_full_i,
  input  logic                 tx_fifo_empty_i,
  input  logic                 tx_done_i,
  input  logic                 req_done_i,
  output logic                 config_req_mst_o
);

  localparam int unsigned PtrW   = $clog2(NUM_REQ);
  localparam int unsigned BurstW = $clog2(MAX_BURST + 1);
  localparam int unsigned OutstW = $clog2(OUTST_DEPTH + 1);

  tx_sched_state_e     state_q, state_d;
  logic [PtrW-1:0]     rr_q, rr_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [BurstW-1:0]   burst_q, burst_d;
  logic [OutstW-1:0]   outst_q, outst_d;
  logic                cfg_pend_q, cfg_pend_d;
  logic                cfg_mst_q, cfg_mst_d;
  logic                cfg_ack_q, cfg_ack_d;

  logic [NUM_REQ-1:0]  arb_gnt;
  logic [NUM_REQ-1:0]  ready;
  logic                wr;
  logic                last;
  logic                dec;
  logic                cfg_busy;
  logic                cfg_set;
  logic [PtrW-1:0]     grantee_idx;
  logic [PtrW-1:0]     rr_next;
  logic [7:0]          tx_data;

  uart_tx_scheduler_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req (req_valid_i),
    .ptr (rr_q),
    .gnt (arb_gnt)
  );

  // Datapath: the grantee's byte goes straight to the FIFO with no latency.
  always_comb begin
    ready   = (state_q == StXfer) ? (grant_q & {NUM_REQ{~tx_fifo_full_i}}) : '0;
    wr      = |(req_valid_i & ready);
    last    = |(req_last_i & grant_q);
    tx_data = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant_q[k]) tx_data = tx_data | req_data_i[8*k +: 8];
    end
    grantee_idx = PtrW'(onehot_to_idx(8'(grant_q)));
    rr_next     = (grantee_idx == PtrW'(NUM_REQ - 1)) ? '0 : grantee_idx + PtrW'(1);
  end

  assign cfg_busy = cfg_pend_q | (state_q == StCfg);
  // Pulses arriving while a configuration is already pending/active are dropped.
  assign cfg_set  = cfg_req_i & ~cfg_busy;
  // A frame completing with nothing outstanding is ignored by the counter.
  assign dec      = tx_done_i & (outst_q != '0);

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    grant_d    = grant_q;
    burst_d    = burst_q;
    cfg_pend_d = cfg_pend_q | cfg_set;
    cfg_mst_d  = cfg_mst_q;
    cfg_ack_d  = 1'b0;

    case (state_q)
      StIdle: begin
        // A same-cycle config pulse already outranks waiting data.
        if (cfg_pend_q || cfg_set) begin
          state_d = StDrain;
        end else if (|req_valid_i) begin
          grant_d = arb_gnt;
          state_d = StXfer;
        end
      end
      StXfer: begin
        if (wr) begin
          if (last || (burst_q == BurstW'(MAX_BURST - 1))) begin
            rr_d    = rr_next;
            grant_d = '0;
            burst_d = '0;
            state_d = StIdle;
          end else begin
            burst_d = burst_q + BurstW'(1);
          end
        end
      end
      StDrain: begin
        if (tx_fifo_empty_i && (outst_q == '0)) begin
          state_d   = StCfg;
          cfg_mst_d = 1'b1;
        end
      end
      StCfg: begin
        if (req_done_i) begin
          state_d    = StIdle;
          cfg_mst_d  = 1'b0;
          cfg_ack_d  = 1'b1;
          cfg_pend_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    outst_d = outst_q;
    case ({wr, dec})
      2'b10:   outst_d = outst_q + OutstW'(1);
      2'b01:   outst_d = outst_q - OutstW'(1);
      default: outst_d = outst_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      rr_q       <= '0;
      grant_q    <= '0;
      burst_q    <= '0;
      outst_q    <= '0;
      cfg_pend_q <= 1'b0;
      cfg_mst_q  <= 1'b0;
      cfg_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      grant_q    <= grant_d;
      burst_q    <= burst_d;
      outst_q    <= outst_d;
      cfg_pend_q <= cfg_pend_d;
      cfg_mst_q  <= cfg_mst_d;
      cfg_ack_q  <= cfg_ack_d;
    end
  end

  // A frame completion with nothing outstanding means transmitter and counter disagree.
  assert property (@(posedge clk_i) disable iff (rst_i) !(tx_done_i && (outst_q == '0)));

  assign req_ready_o      = ready;
  assign grant_o          = grant_q;
  assign tx_fifo_write_o  = wr;
  assign tx_data_o        = tx_data;
  assign cfg_busy_o       = cfg_busy;
  assign cfg_ack_o        = cfg_ack_q;
  assign config_req_mst_o = cfg_mst_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: a requester driver/monitor process
// feeds per-requester packet tables and logs FIFO writes and grants; each
// test task drives a scenario and checks against hand-computed values.
module tb_uart_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [3:0]  grant;
  logic        cfg_req;
  logic        cfg_busy;
  logic        cfg_ack;
  logic [7:0]  tx_data;
  logic        tx_wr;
  logic        tx_full;
  logic        tx_empty;
  logic        tx_done;
  logic        req_done;
  logic        cfg_mst;

  int n_cmp  = 0;
  int n_fail = 0;

  // Packet tables: written by tests, consumed by the driver.
  logic [8:0]  pkt_mem [4][64];
  int          pkt_len [4];
  logic [3:0]  en;
  int          done_count;

  // Driver/monitor state.
  int          pkt_ptr [4];
  logic [7:0]  wlog [256];
  int          wr_count;
  logic [3:0]  glog [64];
  int          g_count;
  int          ep_len [64];
  logic [3:0]  prev_grant;

  always #5 clk = ~clk;

  uart_tx_scheduler #(
    .NUM_REQ     (4),
    .MAX_BURST   (16),
    .OUTST_DEPTH (64)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .req_valid_i      (req_valid),
    .req_data_i       (req_data),
    .req_last_i       (req_last),
    .req_ready_o      (req_ready),
    .grant_o          (grant),
    .cfg_req_i        (cfg_req),
    .cfg_busy_o       (cfg_busy),
    .cfg_ack_o        (cfg_ack),
    .tx_data_o        (tx_data),
    .tx_fifo_write_o  (tx_wr),
    .tx_fifo_full_i   (tx_full),
    .tx_fifo_empty_i  (tx_empty),
    .tx_done_i        (tx_done),
    .req_done_i       (req_done),
    .config_req_mst_o (cfg_mst)
  );

  // Requester driver and write/grant monitor. Samples at negedge, drives at posedge+1.
  initial begin
    logic [3:0] acc;
    req_valid  = '0;
    req_data   = '0;
    req_last   = '0;
    wr_count   = 0;
    g_count    = 0;
    prev_grant = '0;
    for (int k = 0; k < 4; k++) pkt_ptr[k] = 0;
    for (int i = 0; i < 64; i++) ep_len[i] = 0;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      if (grant != 4'b0 && prev_grant == 4'b0) begin
        glog[g_count] = grant;
        g_count++;
      end
      prev_grant = grant;
      if (tx_wr) begin
        wlog[wr_count] = tx_data;
        wr_count++;
        if (g_count > 0) ep_len[g_count-1]++;
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
        if (acc[k]) pkt_ptr[k]++;
        if (en[k] && pkt_ptr[k] < pkt_len[k]) begin
          req_valid[k]       = 1'b1;
          req_data[8*k +: 8] = pkt_mem[k][pkt_ptr[k]][7:0];
          req_last[k]        = pkt_mem[k][pkt_ptr[k]][8];
        end else begin
          req_valid[k]       = 1'b0;
          req_data[8*k +: 8] = 8'h00;
          req_last[k]        = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int k, input logic [7:0] d, input logic l);
    pkt_mem[k][pkt_len[k]] = {l, d};
    pkt_len[k]++;
  endtask

  task automatic wait_writes(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (wr_count < target && n < budget) begin
      tick();
      n++;
    end
    n_cmp++;
    if (wr_count < target) begin
      n_fail++;
      $display("FAIL %s: timeout, writes %0d, required %0d", name, wr_count, target);
    end
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    done_count++;
  endtask

  task automatic drain_all();
    while (done_count < wr_count) pulse_done();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({grant, req_ready, tx_wr} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_grant: got %b/%b/%b, expected 0", grant, req_ready, tx_wr);
    end
    n_cmp++;
    if (tx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_data: got %h, expected 00", tx_data);
    end
    n_cmp++;
    if ({cfg_busy, cfg_ack, cfg_mst} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_cfg: got %b, expected 000", {cfg_busy, cfg_ack, cfg_mst});
    end
  endtask

  task automatic test_round_robin();
    int          bw, bg;
    logic [7:0]  exp_b [8];
    exp_b = '{8'h01, 8'h02, 8'h03, 8'h21, 8'h22, 8'h23, 8'h31, 8'h04};
    bw = wr_count;
    bg = g_count;
    push(0, 8'h01, 1'b0); push(0, 8'h02, 1'b0); push(0, 8'h03, 1'b1);
    push(2, 8'h21, 1'b0); push(2, 8'h22, 1'b0); push(2, 8'h23, 1'b1);
    en[0] = 1'b1;
    en[2] = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({grant, tx_wr, tx_data} !== {4'b0001, 1'b1, 8'h01}) begin
      n_fail++;
      $display("FAIL rr_first_xfer: got g=%b w=%b d=%h, expected g=0001 w=1 d=01",
               grant, tx_wr, tx_data);
    end
    wait_writes(bw + 6, 40, "rr_writes");
    // rr_ptr should now be 3: requester 3 wins over requester 0.
    push(0, 8'h04, 1'b1);
    push(3, 8'h31, 1'b1);
    en[3] = 1'b1;
    wait_writes(bw + 8, 40, "rr_ptr_writes");
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (wlog[bw+i] !== exp_b[i]) begin
        n_fail++;
        $display("FAIL rr_data[%0d]: got %h, expected %h", i, wlog[bw+i], exp_b[i]);
      end
    end
    n_cmp++;
    if (g_count - bg != 4 || glog[bg] !== 4'b0001 || glog[bg+1] !== 4'b0100 ||
        glog[bg+2] !== 4'b1000 || glog[bg+3] !== 4'b0001) begin
      n_fail++;
      $display("FAIL rr_grants: got n=%0d %b %b %b %b, expected n=4 0001 0100 1000 0001",
               g_count - bg, glog[bg], glog[bg+1], glog[bg+2], glog[bg+3]);
    end
  endtask

  task automatic test_burst();
    int         bw, bg;
    logic [7:0] e;
    int         exp_len [4];
    logic [3:0] exp_g [4];
    exp_len = '{16, 2, 16, 8};
    exp_g   = '{4'b0010, 4'b1000, 4'b0010, 4'b0010};
    bw = wr_count;
    bg = g_count;
    for (int j = 0; j < 40; j++) push(1, 8'(32'h40 + j), (j == 39));
    en[1] = 1'b1;
    wait_writes(bw + 5, 40, "burst_first5");
    push(3, 8'hA1, 1'b0);
    push(3, 8'hA2, 1'b1);
    wait_writes(bw + 42, 300, "burst_writes");
    for (int i = 0; i < 42; i++) begin
      if (i < 16)       e = 8'(32'h40 + i);
      else if (i == 16) e = 8'hA1;
      else if (i == 17) e = 8'hA2;
      else              e = 8'(32'h40 + i - 2);
      n_cmp++;
      if (wlog[bw+i] !== e) begin
        n_fail++;
        $display("FAIL burst_data[%0d]: got %h, expected %h", i, wlog[bw+i], e);
      end
    end
    n_cmp++;
    if (g_count - bg != 4) begin
      n_fail++;
      $display("FAIL burst_grant_count: got %0d, expected 4", g_count - bg);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (glog[bg+i] !== exp_g[i] || ep_len[bg+i] != exp_len[i]) begin
        n_fail++;
        $display("FAIL burst_grant[%0d]: got %b/%0d bytes, expected %b/%0d bytes",
                 i, glog[bg+i], ep_len[bg+i], exp_g[i], exp_len[i]);
      end
    end
  endtask

  task automatic test_fifo_full();
    int bw;
    bw = wr_count;
    for (int j = 0; j < 6; j++) push(2, 8'(32'hC0 + j), (j == 5));
    wait_writes(bw + 2, 20, "full_first2");
    tx_full = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_cmp++;
      if ({req_ready, tx_wr} !== 5'b0) begin
        n_fail++;
        $display("FAIL full_stall[%0d]: got ready=%b wr=%b, expected 0", c, req_ready, tx_wr);
      end
    end
    n_cmp++;
    if (grant !== 4'b0100 || wr_count != bw + 2) begin
      n_fail++;
      $display("FAIL full_hold: got g=%b n=%0d, expected g=0100 n=%0d",
               grant, wr_count - bw, 2);
    end
    tx_full = 1'b0;
    wait_writes(bw + 6, 20, "full_resume");
    tick();
    tick();
    n_cmp++;
    if (wr_count != bw + 6) begin
      n_fail++;
      $display("FAIL full_count: got %0d writes, expected 6", wr_count - bw);
    end
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (wlog[bw+i] !== 8'(32'hC0 + i)) begin
        n_fail++;
        $display("FAIL full_data[%0d]: got %h, expected %h", i, wlog[bw+i], 8'(32'hC0 + i));
      end
    end
  endtask

  task automatic test_cfg_midpacket();
    int bw;
    drain_all();
    tx_empty = 1'b0;
    bw = wr_count;
    for (int j = 0; j < 4; j++) push(0, 8'(32'hD0 + j), (j == 3));
    wait_writes(bw + 2, 20, "cfgmid_first2");
    cfg_req = 1'b1;
    tick();
    cfg_req = 1'b0;
    n_cmp++;
    if (cfg_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL cfgmid_busy: got %b, expected 1", cfg_busy);
    end
    wait_writes(bw + 4, 20, "cfgmid_packet");
    for (int c = 0; c < 4; c++) begin
      tick();
      n_cmp++;
      if ({cfg_mst, tx_wr, grant} !== 6'b0) begin
        n_fail++;
        $display("FAIL cfgmid_drain_full[%0d]: got mst=%b wr=%b g=%b, expected 0",
                 c, cfg_mst, tx_wr, grant);
      end
    end
    n_cmp++;
    if (wlog[bw+3] !== 8'hD3 || wr_count != bw + 4) begin
      n_fail++;
      $display("FAIL cfgmid_complete: got last=%h n=%0d, expected D3 n=4",
               wlog[bw+3], wr_count - bw);
    end
    tx_empty = 1'b1;
    pulse_done();
    pulse_done();
    pulse_done();
    tick();
    n_cmp++;
    if (cfg_mst !== 1'b0) begin
      n_fail++;
      $display("FAIL cfgmid_wait_done: got mst=%b, expected 0", cfg_mst);
    end
    pulse_done();
    n_cmp++;
    if (cfg_mst !== 1'b0) begin
      n_fail++;
      $display("FAIL cfgmid_last_done: got mst=%b, expected 0", cfg_mst);
    end
    tick();
    n_cmp++;
    if ({cfg_mst, cfg_busy, cfg_ack} !== 3'b110) begin
      n_fail++;
      $display("FAIL cfgmid_enter_cfg: got mst/busy/ack=%b, expected 110",
               {cfg_mst, cfg_busy, cfg_ack});
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if ({cfg_mst, cfg_ack} !== 2'b10) begin
        n_fail++;
        $display("FAIL cfgmid_hold[%0d]: got mst/ack=%b, expected 10", c, {cfg_mst, cfg_ack});
      end
    end
    req_done = 1'b1;
    tick();
    req_done = 1'b0;
    n_cmp++;
    if ({cfg_mst, cfg_ack, cfg_busy} !== 3'b010) begin
      n_fail++;
      $display("FAIL cfgmid_ack: got mst/ack/busy=%b, expected 010",
               {cfg_mst, cfg_ack, cfg_busy});
    end
    tick();
    n_cmp++;
    if (cfg_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL cfgmid_ack_pulse: got %b, expected 0", cfg_ack);
    end
  endtask

  task automatic test_cfg_idle();
    int bw;
    bw = wr_count;
    push(0, 8'hE0, 1'b1);
    tick();
    cfg_req = 1'b1;
    tick();
    cfg_req = 1'b0;
    n_cmp++;
    if ({cfg_busy, cfg_mst, grant} !== 6'b100000) begin
      n_fail++;
      $display("FAIL cfgidle_drain: got busy=%b mst=%b g=%b, expected 1 0 0000",
               cfg_busy, cfg_mst, grant);
    end
    tick();
    n_cmp++;
    if ({cfg_mst, grant} !== 5'b10000) begin
      n_fail++;
      $display("FAIL cfgidle_cfg: got mst=%b g=%b, expected 1 0000", cfg_mst, grant);
    end
    tick();
    tick();
    n_cmp++;
    if (grant !== 4'b0 || wr_count != bw) begin
      n_fail++;
      $display("FAIL cfgidle_blocked: got g=%b n=%0d, expected 0000 0", grant, wr_count - bw);
    end
    req_done = 1'b1;
    tick();
    req_done = 1'b0;
    n_cmp++;
    if ({cfg_ack, cfg_busy, grant} !== 6'b100000) begin
      n_fail++;
      $display("FAIL cfgidle_ack: got ack=%b busy=%b g=%b, expected 1 0 0000",
               cfg_ack, cfg_busy, grant);
    end
    tick();
    n_cmp++;
    if ({grant, tx_wr, tx_data} !== {4'b0001, 1'b1, 8'hE0}) begin
      n_fail++;
      $display("FAIL cfgidle_grant: got g=%b w=%b d=%h, expected 0001 1 E0",
               grant, tx_wr, tx_data);
    end
    wait_writes(bw + 1, 10, "cfgidle_write");
  endtask

  task automatic test_reset_cfg();
    int bw;
    int n;
    bw = wr_count;
    push(1, 8'hF0, 1'b0);
    push(1, 8'hF1, 1'b1);
    n = 0;
    while (tx_wr !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    n_cmp++;
    if (tx_wr !== 1'b1) begin
      n_fail++;
      $display("FAIL rstcfg_write_seen: got %b, expected 1", tx_wr);
    end
    // Frame completion in the same cycle as a write.
    pulse_done();
    wait_writes(bw + 2, 10, "rstcfg_writes");
    cfg_req = 1'b1;
    tick();
    cfg_req = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (cfg_mst !== 1'b0) begin
      n_fail++;
      $display("FAIL rstcfg_drain2: got mst=%b, expected 0 (2 outstanding)", cfg_mst);
    end
    pulse_done();
    tick();
    tick();
    n_cmp++;
    if (cfg_mst !== 1'b0) begin
      n_fail++;
      $display("FAIL rstcfg_drain1: got mst=%b, expected 0 (1 outstanding)", cfg_mst);
    end
    pulse_done();
    tick();
    n_cmp++;
    if (cfg_mst !== 1'b1) begin
      n_fail++;
      $display("FAIL rstcfg_cfg: got mst=%b, expected 1", cfg_mst);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({cfg_mst, grant, cfg_busy, cfg_ack} !== 7'b0) begin
      n_fail++;
      $display("FAIL rstcfg_reset: got mst=%b g=%b busy=%b ack=%b, expected all 0",
               cfg_mst, grant, cfg_busy, cfg_ack);
    end
    tick();
    n_cmp++;
    if ({cfg_mst, cfg_busy, cfg_ack} !== 3'b0) begin
      n_fail++;
      $display("FAIL rstcfg_no_ack: got mst/busy/ack=%b, expected 000",
               {cfg_mst, cfg_busy, cfg_ack});
    end
  endtask

  initial begin
    rst        = 1'b1;
    cfg_req    = 1'b0;
    tx_full    = 1'b0;
    tx_empty   = 1'b1;
    tx_done    = 1'b0;
    req_done   = 1'b0;
    en         = 4'b0;
    done_count = 0;
    for (int k = 0; k < 4; k++) pkt_len[k] = 0;
    test_reset();
    test_round_robin();
    test_burst();
    test_fifo_full();
    test_cfg_midpacket();
    test_cfg_idle();
    test_reset_cfg();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
